// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, one frame per accepted request, BAUD_DIV clk cycles per bit.
module uart_tx #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transmit,
    input  logic [7:0] TxData,
    output logic       TxD,
    output logic       busy,
    output logic       done
);
    localparam logic [13:0] LAST = 14'(BAUD_DIV - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q;
    logic [9:0]  shift_q;
    logic [3:0]  bit_q;
    logic [13:0] baud_q;
    logic        tx_q, busy_q, done_q;

    assign TxD  = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '1;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (transmit) begin
                        state_q <= SEND;
                        shift_q <= {1'b1, TxData, 1'b0};
                        bit_q   <= '0;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (baud_q == LAST) begin
                        baud_q  <= '0;
                        shift_q <= {1'b1, shift_q[9:1]};
                        // TxD follows the bit that becomes shift_q[0] after this shift
                        tx_q    <= shift_q[1];
                        if (bit_q == 4'd9) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 14'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a fast (BAUD_DIV=4) and a default-rate instance.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int DIV = 4;
    localparam int SDIV = 5208;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_f = 1'b0, tx_s = 1'b0;
    logic [7:0] data_f = '0, data_s = '0;
    logic       txd_f, busy_f, done_f, txd_s, busy_s, done_s;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    uart_tx #(.BAUD_DIV(DIV)) u_fast (
        .clk(clk), .reset(rst_n), .transmit(tx_f), .TxData(data_f),
        .TxD(txd_f), .busy(busy_f), .done(done_f)
    );
    uart_tx u_slow (
        .clk(clk), .reset(rst_n), .transmit(tx_s), .TxData(data_s),
        .TxD(txd_s), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    initial begin
        #6_000_000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    // Records one frame starting with the cycle after the accepting edge, plus the done cycle.
    task automatic capture(input bit slow, input int div, output logic [9:0] bits, output bit stable,
                           output int busy_n, output int done_n, output int done_pos, output logic idle_tx);
        logic t, first;
        int b;
        bits = '1; stable = 1'b1; busy_n = 0; done_n = 0; done_pos = 0; idle_tx = 1'bx; first = 1'b0;
        for (int j = 1; j <= 10 * div + 1; j++) begin
            @(negedge clk);
            t = slow ? txd_s : txd_f;
            if (j <= 10 * div) begin
                b = (j - 1) / div;
                if ((j - 1) % div == div / 2) bits[b] = t;
                if ((j - 1) % div == 0) first = t;
                else if (t !== first) stable = 1'b0;
            end else begin
                idle_tx = t;
            end
            if ((slow ? busy_s : busy_f) === 1'b1) busy_n++;
            if ((slow ? done_s : done_f) === 1'b1) begin
                done_n++;
                if (done_pos == 0) done_pos = j;
            end
        end
    endtask

    task automatic check_frame(input string nm, input int div, input logic [9:0] bits, input bit stable,
                               input int busy_n, input int done_n, input int done_pos, input logic idle_tx);
        logic [7:0] e;
        logic [9:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got frame %b, want a pending byte", nm, bits);
            return;
        end
        e = exp_q.pop_front();
        want = {1'b1, e, 1'b0};
        if (bits !== want) begin
            errors++;
            $display("FAIL %s frame: got %b, want %b", nm, bits, want);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL %s bit_width: got unstable bit slot, want %0d-cycle bits", nm, div);
        end
        checks++;
        if (busy_n != 10 * div) begin
            errors++;
            $display("FAIL %s busy_len: got %0d, want %0d", nm, busy_n, 10 * div);
        end
        checks++;
        if (done_n != 1 || done_pos != 10 * div + 1) begin
            errors++;
            $display("FAIL %s done: got %0d pulses first at %0d, want 1 at %0d", nm, done_n, done_pos, 10 * div + 1);
        end
        checks++;
        if (idle_tx !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_tx: got %b, want 1", nm, idle_tx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({txd_f, busy_f, done_f, txd_s, busy_s, done_s} !== 6'b100_100) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 100100", {txd_f, busy_f, done_f, txd_s, busy_s, done_s});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({txd_f, busy_f, done_f} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_1000: got %0d non-idle cycles, want 0", bad);
        end
    endtask

    task automatic test_single();
        logic [9:0] bits; bit st; int bn, dn, dp; logic it;
        data_f = 8'hA5; tx_f = 1'b1; exp_q.push_back(8'hA5);
        @(posedge clk); #1 tx_f = 1'b0;
        capture(1'b0, DIV, bits, st, bn, dn, dp, it);
        check_frame("single_A5", DIV, bits, st, bn, dn, dp, it);
        repeat (5) @(negedge clk);
        checks++;
        if ({txd_f, busy_f} !== 2'b10) begin
            errors++;
            $display("FAIL single_after: got txd/busy %b, want 10", {txd_f, busy_f});
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits; bit st; int bn, dn, dp; logic it;
        data_f = 8'h00; tx_f = 1'b1; exp_q.push_back(8'h00);
        fork
            begin
                repeat (10) @(negedge clk);
                data_f = 8'hFF;
                exp_q.push_back(8'hFF);
            end
        join_none
        @(posedge clk);
        capture(1'b0, DIV, bits, st, bn, dn, dp, it);
        check_frame("b2b_first", DIV, bits, st, bn, dn, dp, it);
        capture(1'b0, DIV, bits, st, bn, dn, dp, it);
        tx_f = 1'b0;
        check_frame("b2b_second", DIV, bits, st, bn, dn, dp, it);
        repeat (3) @(negedge clk);
        checks++;
        if (busy_f !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got busy %b, want 0", busy_f);
        end
    endtask

    task automatic test_ignore_busy();
        logic [9:0] bits; bit st; int bn, dn, dp; logic it;
        int extra = 0;
        data_f = 8'h3A; tx_f = 1'b1; exp_q.push_back(8'h3A);
        @(posedge clk); #1 tx_f = 1'b0;
        fork
            begin
                repeat (10) @(negedge clk);
                tx_f = 1'b1; data_f = 8'hC3;
                @(negedge clk);
                tx_f = 1'b0;
            end
        join_none
        capture(1'b0, DIV, bits, st, bn, dn, dp, it);
        check_frame("ignore_busy", DIV, bits, st, bn, dn, dp, it);
        repeat (60) begin
            @(negedge clk);
            if (busy_f !== 1'b0 || done_f !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_busy_extra: got %0d busy/done cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits; bit st; int bn, dn, dp; logic it;
        int bad = 0;
        data_f = 8'hF0; tx_f = 1'b1;
        @(posedge clk); #1 tx_f = 1'b0;
        repeat (18) @(negedge clk);
        checks++;
        if ({txd_f, busy_f} !== 2'b01) begin
            errors++;
            $display("FAIL mid_bit3: got txd/busy %b, want 01", {txd_f, busy_f});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({txd_f, busy_f, done_f} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_async: got %b, want 100", {txd_f, busy_f, done_f});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if ({txd_f, busy_f, done_f} !== 3'b100) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset_residual: got %0d non-idle cycles, want 0", bad);
        end
        data_f = 8'h3C; tx_f = 1'b1; exp_q.push_back(8'h3C);
        @(posedge clk); #1 tx_f = 1'b0;
        capture(1'b0, DIV, bits, st, bn, dn, dp, it);
        check_frame("after_reset", DIV, bits, st, bn, dn, dp, it);
    endtask

    task automatic test_default_baud();
        logic [9:0] bits; bit st; int bn, dn, dp; logic it;
        data_s = 8'h55; tx_s = 1'b1; exp_q.push_back(8'h55);
        @(posedge clk); #1 tx_s = 1'b0;
        capture(1'b1, SDIV, bits, st, bn, dn, dp, it);
        check_frame("default_55", SDIV, bits, st, bn, dn, dp, it);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midframe();
        test_default_baud();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover bytes, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
